// File: rtl/issue_controller.sv
// Registered decode/issue stage: valid/ready intake, one-cycle decode latency,
// JZ/JMP sequencing with a fetch-flush window, and LOAD/STORE hold until mem_ack.
module issue_controller #(
    parameter int WIDTH_INSTR  = 24,
    parameter int WIDTH_OPCODE = 4,
    parameter int WA_RF        = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int WIDTH_JDATA  = 16,
    parameter int WA_MEM_SIGN  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WIDTH_INSTR-1:0]  i_instr,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic                    i_zero_valid,
    input  logic                    i_zero,
    input  logic                    i_exe_flush,
    input  logic                    i_mem_ack,
    output logic                    o_dec_valid,
    output logic [WIDTH_OPCODE-1:0] o_opcode,
    output logic [WA_RF-1:0]        o_addr_rega,
    output logic [WA_RF-1:0]        o_addr_regb,
    output logic [WIDTH_VECTOR-1:0] o_data_imm,
    output logic [WIDTH_VECTOR-1:0] o_we_rf,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic                    o_mem_alu,
    output logic [WA_MEM_SIGN-1:0]  o_mem_addr,
    output logic                    o_jump,
    output logic [WIDTH_JDATA-1:0]  o_jump_addr,
    output logic                    o_flush,
    output logic                    o_illegal,
    output logic [15:0]             o_issued_cnt
);

    localparam int CW = $clog2(FLUSH_CYCLES + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);

    localparam logic [WIDTH_OPCODE-1:0] OP_ALU_MAX = WIDTH_OPCODE'(8);
    localparam logic [WIDTH_OPCODE-1:0] OP_JZ      = WIDTH_OPCODE'(9);
    localparam logic [WIDTH_OPCODE-1:0] OP_JMP     = WIDTH_OPCODE'(10);
    localparam logic [WIDTH_OPCODE-1:0] OP_STORE   = WIDTH_OPCODE'(11);
    localparam logic [WIDTH_OPCODE-1:0] OP_LOAD    = WIDTH_OPCODE'(12);
    localparam logic [WIDTH_OPCODE-1:0] OP_NOP     = WIDTH_OPCODE'(13);

    typedef enum logic [2:0] {
        S_RUN,
        S_BR_WAIT,
        S_JUMP,
        S_FLUSH,
        S_MEM_WAIT
    } state_t;

    // With a zero-length window every flush entry collapses straight back to RUN.
    localparam state_t S_FL_ENTRY = (FLUSH_CYCLES == 0) ? S_RUN : S_FLUSH;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    r_pend, w_pend_nxt;

    logic                    r_dec_valid;
    logic [WIDTH_OPCODE-1:0] r_opcode;
    logic [WA_RF-1:0]        r_rega;
    logic [WA_RF-1:0]        r_regb;
    logic [WIDTH_VECTOR-1:0] r_imm;
    logic [WIDTH_VECTOR-1:0] r_we_rf;
    logic [WIDTH_JDATA-1:0]  r_jdata;
    logic                    r_is_store;
    logic                    r_illegal;
    logic [15:0]             r_issued_cnt;

    logic [WIDTH_OPCODE-1:0] w_op;
    logic [WA_RF-1:0]        w_rega;
    logic [WA_RF-1:0]        w_regb;
    logic [WIDTH_VECTOR-1:0] w_imm;
    logic [WIDTH_JDATA-1:0]  w_jdata;
    logic [WIDTH_VECTOR-1:0] w_lane_we;
    logic                    w_accept;
    logic                    w_rsvd;

    assign w_op    = i_instr[WIDTH_INSTR-1 -: WIDTH_OPCODE];
    assign w_rega  = i_instr[WIDTH_INSTR-WIDTH_OPCODE-1 -: WA_RF];
    assign w_regb  = i_instr[WIDTH_INSTR-WIDTH_OPCODE-WA_RF-1 -: WA_RF];
    assign w_imm   = i_instr[WIDTH_VECTOR-1:0];
    assign w_jdata = i_instr[WIDTH_JDATA-1:0];

    assign o_instr_ready = (r_state == S_RUN) && !i_exe_flush && i_rst_n;
    assign w_accept      = i_instr_valid && o_instr_ready;
    assign w_rsvd        = (w_op > OP_NOP);
    assign w_lane_we     = ((w_op <= OP_ALU_MAX) || (w_op == OP_LOAD)) ? w_imm : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_RUN: begin
                if (i_exe_flush) begin
                    w_state_nxt = S_FL_ENTRY;
                    w_cnt_nxt   = CNT_LOAD;
                end else if (w_accept) begin
                    if (w_op == OP_JZ)
                        w_state_nxt = S_BR_WAIT;
                    else if (w_op == OP_JMP)
                        w_state_nxt = S_JUMP;
                    else if ((w_op == OP_STORE) || (w_op == OP_LOAD))
                        w_state_nxt = S_MEM_WAIT;
                end
            end
            S_BR_WAIT: begin
                // A flush cancels the branch even when the zero flag arrives together with it.
                if (i_exe_flush) begin
                    w_state_nxt = S_FL_ENTRY;
                    w_cnt_nxt   = CNT_LOAD;
                end else if (i_zero_valid) begin
                    w_state_nxt = i_zero ? S_JUMP : S_RUN;
                end
            end
            S_JUMP: begin
                w_state_nxt = S_FL_ENTRY;
                w_cnt_nxt   = CNT_LOAD;
            end
            S_FLUSH: begin
                if (i_exe_flush)
                    w_cnt_nxt = CNT_LOAD;
                else if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else
                    w_cnt_nxt = r_cnt - CW'(1);
            end
            S_MEM_WAIT: begin
                w_pend_nxt = r_pend || i_exe_flush;
                if (i_mem_ack) begin
                    w_pend_nxt = 1'b0;
                    if (r_pend || i_exe_flush) begin
                        w_state_nxt = S_FL_ENTRY;
                        w_cnt_nxt   = CNT_LOAD;
                    end else
                        w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // Decode fields only move on accept; the lane mask is a one-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dec_valid  <= 1'b0;
            r_opcode     <= '0;
            r_rega       <= '0;
            r_regb       <= '0;
            r_imm        <= '0;
            r_we_rf      <= '0;
            r_jdata      <= '0;
            r_is_store   <= 1'b0;
            r_illegal    <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            r_dec_valid <= w_accept;
            r_we_rf     <= w_accept ? w_lane_we : '0;
            if (w_accept) begin
                r_opcode     <= w_rsvd ? OP_NOP : w_op;
                r_rega       <= w_rega;
                r_regb       <= w_regb;
                r_imm        <= w_imm;
                r_jdata      <= w_jdata;
                r_is_store   <= (w_op == OP_STORE);
                r_illegal    <= r_illegal || w_rsvd;
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
        end
    end

    assign o_dec_valid  = r_dec_valid;
    assign o_opcode     = r_opcode;
    assign o_addr_rega  = r_rega;
    assign o_addr_regb  = r_regb;
    assign o_data_imm   = r_imm;
    assign o_we_rf      = r_we_rf;
    assign o_mem_req    = (r_state == S_MEM_WAIT);
    assign o_mem_we     = o_mem_req && r_is_store;
    assign o_mem_alu    = o_mem_req && !r_is_store;
    assign o_mem_addr   = r_jdata[WA_MEM_SIGN-1:0];
    assign o_jump       = (r_state == S_JUMP);
    assign o_jump_addr  = r_jdata;
    assign o_flush      = (r_state == S_FLUSH);
    assign o_illegal    = r_illegal;
    assign o_issued_cnt = r_issued_cnt;

endmodule
